// File: rtl/dsp_cmd_ctrl_if.sv
// GPIO command/response and log-memory bus between the MicroBlaze side and dsp_cmd_ctrl.
// The slave modport is the controller's view; master is the micro/memory view.
interface dsp_cmd_ctrl_if #(
    parameter int unsigned NB_GPIO = 32,
    parameter int unsigned NB_ADDR = 10
);
    logic [NB_GPIO-1:0] gpo;
    logic [NB_GPIO-1:0] gpi;
    logic               log_run;
    logic               log_full;
    logic [NB_ADDR-1:0] log_addr;
    logic [NB_GPIO-1:0] log_data;

    modport master (
        output gpo,
        output log_full,
        output log_data,
        input  gpi,
        input  log_run,
        input  log_addr
    );

    modport slave (
        input  gpo,
        input  log_full,
        input  log_data,
        output gpi,
        output log_run,
        output log_addr
    );
endinterface

// File: rtl/dsp_cmd_ctrl.sv
// MicroBlaze GPIO command decoder: rising edges of the enable bit launch one command
// that drives DSP config outputs, starts/stops a log capture run or reads log memory.
module dsp_cmd_ctrl #(
    parameter int unsigned NB_GPIO = 32,
    parameter int unsigned NB_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    dsp_cmd_ctrl_if.slave        bus,
    output logic                 o_dsp_rst,
    output logic                 o_tx_en,
    output logic                 o_rx_en,
    output logic [1:0]           o_phase
);

    localparam int unsigned NB_OP  = 8;
    localparam int unsigned EN_IDX = NB_GPIO - NB_OP - 1;
    localparam int unsigned NB_PAY = EN_IDX;

    localparam logic [NB_OP-1:0] OP_DSP_RST  = 8'h01;
    localparam logic [NB_OP-1:0] OP_TX_EN    = 8'h02;
    localparam logic [NB_OP-1:0] OP_RX_EN    = 8'h03;
    localparam logic [NB_OP-1:0] OP_PHASE    = 8'h04;
    localparam logic [NB_OP-1:0] OP_LOG_RUN  = 8'h05;
    localparam logic [NB_OP-1:0] OP_LOG_READ = 8'h06;
    localparam logic [NB_OP-1:0] OP_STATUS   = 8'h07;

    typedef struct packed {
        logic [NB_OP-1:0]  op;
        logic [NB_PAY-1:0] pay;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        LOG_WAIT,
        READ_WAIT,
        READ_CAP
    } state_t;

    state_t             state_q, state_d;
    logic               en_q;
    cmd_t               cmd_q, cmd_d;
    logic               log_first_q, log_first_d;
    logic               dsp_rst_q, dsp_rst_d;
    logic               tx_en_q, tx_en_d;
    logic               rx_en_q, rx_en_d;
    logic [1:0]         phase_q, phase_d;
    logic               log_run_q, log_run_d;
    logic [NB_ADDR-1:0] log_addr_q, log_addr_d;
    logic [NB_GPIO-1:0] gpi_q, gpi_d;

    logic   accept_c;
    cmd_t   gpo_cmd_c;
    state_t done_state_c;
    logic   unused_pay;

    assign accept_c     = bus.gpo[EN_IDX] & ~en_q;
    assign gpo_cmd_c    = cmd_t'({bus.gpo[NB_GPIO-1 -: NB_OP], bus.gpo[NB_PAY-1:0]});
    // A finished command resumes watching the capture run if one is still going.
    assign done_state_c = log_run_q ? LOG_WAIT : IDLE;
    assign unused_pay   = ^cmd_q.pay[NB_PAY-1:NB_ADDR];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            cmd_q       <= '0;
            log_first_q <= 1'b0;
            dsp_rst_q   <= 1'b1;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            phase_q     <= 2'd0;
            log_run_q   <= 1'b0;
            log_addr_q  <= '0;
            gpi_q       <= '0;
        end else begin
            en_q        <= bus.gpo[EN_IDX];
            cmd_q       <= cmd_d;
            log_first_q <= log_first_d;
            dsp_rst_q   <= dsp_rst_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            phase_q     <= phase_d;
            log_run_q   <= log_run_d;
            log_addr_q  <= log_addr_d;
            gpi_q       <= gpi_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        log_first_d = log_first_q;
        dsp_rst_d   = dsp_rst_q;
        tx_en_d     = tx_en_q;
        rx_en_d     = rx_en_q;
        phase_d     = phase_q;
        log_run_d   = log_run_q;
        log_addr_d  = log_addr_q;
        gpi_d       = gpi_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cmd_d   = gpo_cmd_c;
                    state_d = EXEC;
                end
            end

            LOG_WAIT: begin
                log_first_d = 1'b0;
                if (!log_first_q && bus.log_full) begin
                    log_run_d = 1'b0;
                    state_d   = IDLE;
                end
                if (accept_c) begin
                    cmd_d   = gpo_cmd_c;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = done_state_c;
                case (cmd_q.op)
                    OP_DSP_RST: begin
                        dsp_rst_d = cmd_q.pay[0];
                        gpi_d     = '0;
                    end
                    OP_TX_EN: begin
                        tx_en_d = cmd_q.pay[0];
                        gpi_d   = '0;
                    end
                    OP_RX_EN: begin
                        rx_en_d = cmd_q.pay[0];
                        gpi_d   = '0;
                    end
                    OP_PHASE: begin
                        phase_d = cmd_q.pay[1:0];
                        gpi_d   = '0;
                    end
                    OP_LOG_RUN: begin
                        if (!log_run_q) begin
                            log_run_d   = 1'b1;
                            log_first_d = 1'b1;
                            gpi_d       = '0;
                            state_d     = LOG_WAIT;
                        end
                    end
                    OP_LOG_READ: begin
                        if (!log_run_q) begin
                            log_addr_d = cmd_q.pay[NB_ADDR-1:0];
                            state_d    = READ_WAIT;
                        end
                    end
                    OP_STATUS: begin
                        gpi_d = NB_GPIO'({log_run_q, bus.log_full});
                    end
                    default: begin
                        gpi_d = '1;
                    end
                endcase
            end

            // Memory read data becomes valid one cycle after the address.
            READ_WAIT: begin
                state_d = READ_CAP;
            end

            READ_CAP: begin
                gpi_d   = bus.log_data;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gpi      = gpi_q;
    assign bus.log_run  = log_run_q;
    assign bus.log_addr = log_addr_q;
    assign o_dsp_rst    = dsp_rst_q;
    assign o_tx_en      = tx_en_q;
    assign o_rx_en      = rx_en_q;
    assign o_phase      = phase_q;

endmodule

// File: tb/tb_dsp_cmd_ctrl.sv
// Directed bench for dsp_cmd_ctrl: a vector table of single commands plus
// hand-timed sequences for latency, level-hold, capture run and reset abort.
module tb_dsp_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic       o_dsp_rst;
    logic       o_tx_en;
    logic       o_rx_en;
    logic [1:0] o_phase;

    int n_tests;
    int n_fail;

    dsp_cmd_ctrl_if #(.NB_GPIO(32), .NB_ADDR(10)) bus ();

    dsp_cmd_ctrl #(.NB_GPIO(32), .NB_ADDR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .o_dsp_rst (o_dsp_rst),
        .o_tx_en   (o_tx_en),
        .o_rx_en   (o_rx_en),
        .o_phase   (o_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log memory model: registered read, data = addr ^ 0xA5A5_0000
    always @(posedge clk) bus.log_data <= 32'(bus.log_addr) ^ 32'hA5A5_0000;

    typedef struct {
        logic [7:0]  op;
        logic [22:0] pay;
        logic        full;
        logic [31:0] gpi;
        logic        d;
        logic        t;
        logic        r;
        logic [1:0]  ph;
        logic [9:0]  addr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic en, input logic [22:0] pay);
        return {op, en, pay};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0]  = '{8'h03, 23'h000001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'd0, 10'h000};
        vecs[1]  = '{8'h04, 23'h000002, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'd2, 10'h000};
        vecs[2]  = '{8'h07, 23'h000000, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 2'd2, 10'h000};
        vecs[3]  = '{8'hFF, 23'h000000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'd2, 10'h000};
        vecs[4]  = '{8'h07, 23'h000000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'd2, 10'h000};
        vecs[5]  = '{8'h06, 23'h0003A5, 1'b0, 32'hA5A5_03A5, 1'b0, 1'b1, 1'b1, 2'd2, 10'h3A5};
        vecs[6]  = '{8'h00, 23'h000003, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'd2, 10'h3A5};
        vecs[7]  = '{8'h04, 23'h7FFFFD, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 2'd1, 10'h3A5};
        vecs[8]  = '{8'h06, 23'h7FFC01, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 2'd1, 10'h001};
        vecs[9]  = '{8'h01, 23'h000001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 2'd1, 10'h001};
        vecs[10] = '{8'h02, 23'h7FFFFE, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'd1, 10'h001};
        vecs[11] = '{8'h08, 23'h000001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 2'd1, 10'h001};

        rst          = 1'b1;
        bus.gpo      = '0;
        bus.log_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cfg", 64'({o_dsp_rst, o_tx_en, o_rx_en, o_phase, bus.log_run, bus.log_addr}),
              64'({1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'h000}));
        check("reset_gpi", 64'(bus.gpi), 64'h0);

        // Enable high on the first cycle after release; two-edge latency to o_dsp_rst
        rst     = 1'b0;
        bus.gpo = 32'h0180_0000;
        @(negedge clk);
        bus.gpo = 32'h0;
        check("latency_edge1", 64'(o_dsp_rst), 64'h1);
        @(negedge clk);
        check("latency_edge2", 64'(o_dsp_rst), 64'h0);
        check("latency_gpi", 64'(bus.gpi), 64'h0);
        repeat (3) @(negedge clk);

        // Level-held enable executes only once; payload change mid-hold is ignored
        bus.gpo = mk(8'h02, 1'b1, 23'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 5) bus.gpo = mk(8'h02, 1'b1, 23'd0);
        end
        bus.gpo = 32'h0;
        repeat (5) @(negedge clk);
        check("hold_tx_en", 64'(o_tx_en), 64'h1);
        check("hold_gpi", 64'(bus.gpi), 64'h0);

        // Capture run with full ignored on first wait cycle, STATUS and LOG_READ mid-run
        bus.gpo = 32'h0580_0000;
        @(negedge clk);
        bus.gpo = 32'h0;
        @(negedge clk);
        check("run_start", 64'(bus.log_run), 64'h1);
        bus.log_full = 1'b1;
        @(negedge clk);
        check("run_first_ignored", 64'(bus.log_run), 64'h1);
        bus.log_full = 1'b0;
        bus.gpo      = 32'h0780_0000;
        @(negedge clk);
        bus.gpo = 32'h0;
        @(negedge clk);
        check("status_mid_run", 64'(bus.gpi), 64'h2);
        bus.gpo = 32'h0680_0123;
        @(negedge clk);
        bus.gpo = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("read_mid_run_gpi", 64'(bus.gpi), 64'h2);
        check("read_mid_run_addr", 64'(bus.log_addr), 64'h0);
        check("run_before_full", 64'(bus.log_run), 64'h1);
        bus.log_full = 1'b1;
        @(negedge clk);
        check("run_after_full", 64'(bus.log_run), 64'h0);
        bus.log_full = 1'b0;
        repeat (3) @(negedge clk);

        // Single-command vector table
        for (int v = 0; v < 12; v++) begin
            bus.log_full = vecs[v].full;
            bus.gpo      = mk(vecs[v].op, 1'b1, vecs[v].pay);
            @(negedge clk);
            bus.gpo = mk(vecs[v].op, 1'b0, vecs[v].pay);
            repeat (5) @(negedge clk);
            check($sformatf("vec%0d_gpi", v), 64'(bus.gpi), 64'(vecs[v].gpi));
            check($sformatf("vec%0d_cfg", v),
                  64'({o_dsp_rst, o_tx_en, o_rx_en, o_phase, bus.log_run, bus.log_addr}),
                  64'({vecs[v].d, vecs[v].t, vecs[v].r, vecs[v].ph, 1'b0, vecs[v].addr}));
        end
        bus.log_full = 1'b0;
        bus.gpo      = 32'h0;
        repeat (2) @(negedge clk);

        // Reset during READ_WAIT aborts the read
        bus.gpo = 32'h0680_0055;
        @(negedge clk);
        bus.gpo = 32'h0;
        @(negedge clk);
        check("read_wait_addr", 64'(bus.log_addr), 64'h055);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cfg", 64'({o_dsp_rst, o_tx_en, o_rx_en, o_phase, bus.log_run, bus.log_addr}),
              64'({1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'h000}));
        check("abort_gpi", 64'(bus.gpi), 64'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_abort_gpi", 64'(bus.gpi), 64'h0);
        check("post_abort_addr", 64'(bus.log_addr), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_cmd_ctrl.md
DSP_CMD_CTRL -- requirements
Module: dsp_cmd_ctrl

Interface
REQ-001 Parameter NB_GPIO, default 32: width of the GPIO words exchanged with the MicroBlaze.
REQ-002 Parameter NB_ADDR, default 10: log-memory address width.
REQ-003 clk  input  1  DSP-domain clock (clockdsp); the GPIO words are synchronous to it.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_gpo  input  NB_GPIO  command word from the micro: [31:24] opcode, [23] enable, [22:0] payload.
REQ-006 o_gpi  output  NB_GPIO  response word to the micro.
REQ-007 o_dsp_rst  output  1  reset to the DSP datapath.
REQ-008 o_tx_en, o_rx_en  output  1 each  DSP transmitter and receiver enables.
REQ-009 o_phase  output  2  receiver sampling-phase select.
REQ-010 o_log_run  output  1  capture-run request to the log memory.
REQ-011 i_log_full  input  1  log memory full.
REQ-012 o_log_addr  output  NB_ADDR  log-memory read address.
REQ-013 i_log_data  input  NB_GPIO  log-memory read data, valid one cycle after o_log_addr.

Function
REQ-014 The block registers i_gpo[23] every cycle. A command is accepted only at an edge where i_gpo[23]=1 and the registered value is 0; level-high and falling edges are ignored.
REQ-015 On acceptance, opcode and payload are latched. The FSM moves IDLE->EXEC, and the command takes effect at the next edge (1-cycle latency).
REQ-016 FSM states: IDLE, EXEC, LOG_WAIT, READ_WAIT, READ_CAP.
REQ-017 0x01: o_dsp_rst <= payload[0].
- 0x02: o_tx_en <= payload[0].
- 0x03: o_rx_en <= payload[0].
- 0x04: o_phase <= payload[1:0].
- Each of these sets o_gpi <= 0 and returns the FSM to IDLE, or to LOG_WAIT if a run is active.
REQ-018 0x05 LOG_RUN: EXEC->LOG_WAIT, o_log_run <= 1, o_gpi <= 0.
REQ-019 In LOG_WAIT, i_log_full is ignored during the first cycle. Thereafter, i_log_full=1 clears o_log_run and the FSM returns to IDLE.
REQ-020 0x06 LOG_READ, step 1: EXEC->READ_WAIT with o_log_addr <= payload[NB_ADDR-1:0].
REQ-021 0x06 LOG_READ, step 2: READ_WAIT->READ_CAP, then READ_CAP->IDLE with o_gpi <= i_log_data. o_gpi is therefore updated 3 edges after acceptance.
REQ-022 0x07 STATUS: o_gpi <= {zeros, busy, i_log_full}, where busy = o_log_run.
REQ-023 Any other opcode: o_gpi <= 32'hFFFF_FFFF; no other output changes.
REQ-024 While o_log_run=1, further 0x05 and 0x06 commands are ignored: o_gpi and the run state are unchanged. Opcodes 0x01–0x04, 0x07 and unknown opcodes still execute, and the run continues.
REQ-025 An enable edge arriving while the FSM is in EXEC, READ_WAIT or READ_CAP is dropped, with no queueing. Software must space edges by at least 4 cycles.
REQ-026 o_gpi holds its last value until the next response-producing command completes.
REQ-027 o_log_addr holds its value after a read completes.

Reset
REQ-028 Reset values:
- o_dsp_rst = 1.
- o_tx_en, o_rx_en, o_log_run = 0.
- o_phase, o_log_addr, o_gpi = 0.
- FSM = IDLE; registered enable = 0.
REQ-029 Reset asserted mid-run or mid-read aborts the operation: outputs return to the REQ-028 values at the next edge.
REQ-030 If i_gpo[23]=1 on the first cycle after reset release, it is accepted as a command (registered enable is 0).

Verification
REQ-031 Release rst, then i_gpo = 0x0180_0000 (0x01, payload 0) -> o_dsp_rst goes 1->0 exactly 2 edges after the enable edge is sampled; o_gpi = 0.
REQ-032 Hold i_gpo[23]=1 for 10 cycles with opcode 0x02, payload 1 -> o_tx_en = 1, and exactly one command is executed (toggle payload mid-hold: no change).
REQ-033 Issue 0x05 with i_log_full = 1 on the first LOG_WAIT cycle, then 0 for 5 cycles, then 1 -> o_log_run stays 1 until the cycle after full is reasserted, then 0. STATUS issued mid-run returns 0x0000_0002.
REQ-034 Issue 0x06 with payload 0x3A5, memory model returning addr^0xA5A5_0000 -> o_log_addr = 0x3A5 and o_gpi = 0xA5A5_03A5 on the third edge after acceptance. A 0x06 issued during a run leaves o_gpi unchanged.
REQ-035 Opcode 0xFF -> o_gpi = 0xFFFF_FFFF with all config outputs unchanged. Assert rst during READ_WAIT -> all outputs at the REQ-028 values next edge, and o_gpi is not overwritten afterwards.
